bcd_counter_bank: RTL and testbench

- Multi-digit BCD event counter directly downstream of the input trigger/debounce stage.
- Consumes that stage's increment pulse, per-digit trigger mask and refresh pulse.
- Adds 1 to each masked digit and ripples carries one digit per clock.
- Snapshots the count into a display register on refresh, and time-multiplexes the display register onto a single 4-bit digit bus for the 7-segment driver.

---
 rtl/bcd_counter_bank.sv | 152 +++++++++++++++
 tb/tb_bcd_counter_bank.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_bank.sv
// Multi-digit BCD event counter with ripple carry, refresh snapshot and display scan.
// Increment: digit updates one edge after inc_pulse; carries move one digit per edge (<= DIGITS+1 edges).
// No backpressure: inc_pulse while busy is dropped; refresh during busy is held and latched once idle.
module bcd_counter_bank #(
  parameter int DIGITS   = 6,
  parameter int SCAN_DIV = 1000,
  parameter int SCAN_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc_pulse,
  input  logic [DIGITS-1:0]     inc_mask,
  input  logic                  ref_pulse,
  input  logic                  clr,
  output logic                  busy,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   display_bcd,
  output logic [DIGITS-1:0]     scan_sel,
  output logic [3:0]            scan_bcd
);

  typedef enum logic {IDLE, CARRY} state_t;

  state_t                state, state_next;
  logic [4*DIGITS-1:0]   cnt, cnt_next;
  logic [DIGITS-1:0]     pend, pend_next;
  logic [DIGITS-1:0]     carry;
  logic                  ovf_next;
  logic                  start;
  logic                  latch_ok;
  logic                  do_latch;
  logic                  ref_pending;
  logic [SCAN_W-1:0]     scan_cnt;
  logic [3:0]            sel_digit;

  // An increment is accepted only from IDLE with a non-empty mask; clear always wins.
  assign start    = (state == IDLE) && inc_pulse && (|inc_mask) && !clr;
  // The snapshot is only taken when the count is settled and not about to change.
  assign latch_ok = (state == IDLE) && !start;
  assign do_latch = (ref_pulse || ref_pending) && latch_ok;
  assign busy     = (state == CARRY);

  // Next-state logic: accept masks, step every pending digit, forward carries one digit up.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pend_next  = pend;
    ovf_next   = overflow;
    carry      = '0;
    if (clr) begin
      state_next = IDLE;
      cnt_next   = '0;
      pend_next  = '0;
      ovf_next   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pend_next  = inc_mask;
            state_next = CARRY;
          end
        end
        CARRY: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (pend[i]) begin
              if (cnt[4*i +: 4] == 4'd9) begin
                cnt_next[4*i +: 4] = 4'd0;
                carry[i]           = 1'b1;
              end else begin
                cnt_next[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
              end
            end
          end
          // A carry into a digit that was also masked lands next cycle, so nothing is lost.
          pend_next[0] = 1'b0;
          for (int i = 1; i < DIGITS; i++) begin
            pend_next[i] = carry[i-1];
          end
          if (carry[DIGITS-1]) begin
            ovf_next = 1'b1;
          end
          state_next = (|pend_next) ? CARRY : IDLE;
        end
        default: begin
          state_next = IDLE;
          pend_next  = '0;
        end
      endcase
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      pend     <= pend_next;
      overflow <= ovf_next;
    end
  end

  // Refresh snapshot; repeated refresh requests while waiting collapse into one latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      display_bcd <= '0;
      ref_pending <= 1'b0;
    end else if (do_latch) begin
      display_bcd <= cnt;
      ref_pending <= 1'b0;
    end else if (ref_pulse) begin
      ref_pending <= 1'b1;
    end
  end

  // Scan slot timer and one-hot digit rotation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      scan_sel <= DIGITS'(1);
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_sel <= (scan_sel << 1) | (scan_sel >> (DIGITS - 1));
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Pick the display digit addressed by the current select.
  always_comb begin
    sel_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_sel[i]) begin
        sel_digit = display_bcd[4*i +: 4];
      end
    end
  end

  // Registered digit bus towards the segment driver.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_bcd <= 4'd0;
    end else begin
      scan_bcd <= sel_digit;
    end
  end

endmodule

// File: tb/tb_bcd_counter_bank.sv
// Randomised and directed bench for bcd_counter_bank against a decimal-digit reference model.
// Outputs are compared every cycle, 1 time unit after the rising edge.
// The bench drives all inputs; the DUT has no backpressure towards it.
module tb_bcd_counter_bank;

  localparam int ND = 6;
  localparam int SD = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            inc_pulse;
  logic [ND-1:0]   inc_mask;
  logic            ref_pulse;
  logic            clr;
  logic            busy;
  logic            overflow;
  logic [4*ND-1:0] display_bcd;
  logic [ND-1:0]   scan_sel;
  logic [3:0]      scan_bcd;

  bcd_counter_bank #(.DIGITS(ND), .SCAN_DIV(SD), .SCAN_W(16)) dut (
    .clk(clk), .reset(reset), .inc_pulse(inc_pulse), .inc_mask(inc_mask),
    .ref_pulse(ref_pulse), .clr(clr), .busy(busy), .overflow(overflow),
    .display_bcd(display_bcd), .scan_sel(scan_sel), .scan_bcd(scan_bcd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;

  // Reference model: count digits, digits still owed a +1, display digits, scan position.
  int        md [ND];
  bit [ND-1:0] mowe;
  bit        mbusy, movf, mrefp;
  int        mdisp [ND];
  int        mcnt, msel, mscan;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input int a [ND]);
    logic [31:0] v = '0;
    for (int i = 0; i < ND; i++) v = v | (32'(a[i]) << (4*i));
    return v;
  endfunction

  function automatic void mreset();
    for (int i = 0; i < ND; i++) begin md[i] = 0; mdisp[i] = 0; end
    mowe = '0; mbusy = 0; movf = 0; mrefp = 0;
    mcnt = 0; msel = 0; mscan = 0;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  function automatic void model_edge();
    bit start, elig;
    bit [ND-1:0] nowe;
    start = !mbusy && inc_pulse && (inc_mask != 0) && !clr;
    elig  = !mbusy && !start;
    mscan = mdisp[msel];
    if (mcnt == SD-1) begin mcnt = 0; msel = (msel + 1) % ND; end
    else mcnt++;
    if ((ref_pulse || mrefp) && elig) begin mdisp = md; mrefp = 0; end
    else if (ref_pulse) mrefp = 1;
    if (clr) begin
      for (int i = 0; i < ND; i++) md[i] = 0;
      mowe = '0; mbusy = 0; movf = 0;
    end else if (start) begin
      mowe = inc_mask; mbusy = 1;
    end else if (mbusy) begin
      nowe = '0;
      for (int i = 0; i < ND; i++) begin
        if (mowe[i]) begin
          md[i] = (md[i] + 1) % 10;
          if (md[i] == 0) begin
            if (i == ND-1) movf = 1;
            else nowe[i+1] = 1;
          end
        end
      end
      mowe = nowe;
      mbusy = (nowe != 0);
    end
  endfunction

  task automatic compare();
    check("busy", 32'(busy), 32'(mbusy));
    check("overflow", 32'(overflow), 32'(movf));
    check("display_bcd", 32'(display_bcd), pack(mdisp));
    check("scan_sel", 32'(scan_sel), 32'(1) << msel);
    check("scan_bcd", 32'(scan_bcd), 32'(mscan));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    if (busy) busy_cnt++;
    compare();
  endtask

  task automatic idle(input int n);
    inc_pulse = 0; inc_mask = '0; ref_pulse = 0; clr = 0;
    repeat (n) cycle();
  endtask

  task automatic pulse(input logic [ND-1:0] m, input int gap);
    inc_pulse = 1; inc_mask = m;
    cycle();
    idle(gap);
  endtask

  task automatic do_ref();
    ref_pulse = 1; cycle(); idle(2);
  endtask

  task automatic do_clr();
    clr = 1; cycle(); idle(1);
  endtask

  task automatic preload(input logic [ND-1:0] m, input int n);
    repeat (n) pulse(m, 9);
  endtask

  initial begin
    logic [ND-1:0] m;
    reset = 1; inc_pulse = 0; inc_mask = '0; ref_pulse = 0; clr = 0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    compare();
    check("reset_sel", 32'(scan_sel), 32'h1);
    reset = 0;
    idle(3);

    // Three single-digit increments, each busy for exactly one cycle.
    busy_cnt = 0;
    repeat (3) pulse(6'b000001, 11);
    check("busy_cycles_x3", 32'(busy_cnt), 32'd3);
    do_ref();
    check("disp_3", 32'(display_bcd), 32'h000003);
    check("ovf_0", 32'(overflow), 32'd0);

    // 099999 + 1 ripples over six edges.
    do_clr();
    preload(6'b011111, 9);
    busy_cnt = 0;
    pulse(6'b000001, 10);
    check("busy_cycles_ripple", 32'(busy_cnt), 32'd6);
    do_ref();
    check("disp_100000", 32'(display_bcd), 32'h100000);

    // 999999 + 1 wraps and sets sticky overflow; clear drops it but keeps the display.
    do_clr();
    preload(6'b111111, 9);
    pulse(6'b000001, 10);
    idle(5);
    check("ovf_sticky", 32'(overflow), 32'd1);
    do_clr();
    check("ovf_cleared", 32'(overflow), 32'd0);
    check("disp_kept", 32'(display_bcd), 32'h100000);

    // 000009 with mask 000011: carry into the masked digit is applied a cycle later.
    preload(6'b000001, 9);
    pulse(6'b000011, 10);
    do_ref();
    check("disp_20", 32'(display_bcd), 32'h000020);

    // Refresh during carry waits; an increment during busy is dropped.
    do_clr();
    preload(6'b000111, 9);
    inc_pulse = 1; inc_mask = 6'b000001; cycle();
    inc_pulse = 0; inc_mask = '0; ref_pulse = 1; cycle();
    ref_pulse = 0; inc_pulse = 1; inc_mask = 6'b000001; cycle();
    check("disp_held", 32'(display_bcd), 32'h000020);
    idle(8);
    check("disp_1000", 32'(display_bcd), 32'h001000);
    do_ref();
    check("disp_1000_again", 32'(display_bcd), 32'h001000);

    // Scan a 654321 snapshot, then reset asynchronously in the middle of a slot.
    do_clr();
    for (int k = 0; k < ND; k++) begin
      m = '0;
      for (int j = 0; j < ND; j++) if (j + 1 > k) m[j] = 1'b1;
      pulse(m, 9);
    end
    do_ref();
    check("disp_654321", 32'(display_bcd), 32'h654321);
    idle(4*ND*2 + 3);
    #3 reset = 1;
    #1;
    check("arst_sel", 32'(scan_sel), 32'h1);
    check("arst_bcd", 32'(scan_bcd), 32'h0);
    check("arst_disp", 32'(display_bcd), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    reset = 0;
    mreset();
    compare();
    idle(2);

    // Reset in the middle of a carry chain leaves nothing behind.
    preload(6'b011111, 9);
    inc_pulse = 1; inc_mask = 6'b000001; cycle();
    idle(2);
    #2 reset = 1;
    #1;
    check("arst_carry_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    reset = 0;
    mreset();
    idle(10);
    do_ref();
    check("arst_carry_disp", 32'(display_bcd), 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      inc_pulse = ($urandom_range(0, 3) == 0);
      inc_mask  = ND'($urandom);
      clr       = ($urandom_range(0, 63) == 0);
      ref_pulse = !clr && ($urandom_range(0, 7) == 0);
      cycle();
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
